// File: rtl/spi_txn_engine.sv
// SPI mode-0 master for the 23K-style program/data SRAMs: shifts out a 0..4 byte MSB-first
// burst on si/sck, optionally clocks one byte back in from so, and pulses done when finished.
module spi_txn_engine #(
  parameter int DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] write_data,
  input  logic [2:0]  write_len,
  input  logic        read_len,
  output logic [7:0]  read_data,
  output logic        done,
  output logic        busy,
  output logic        sck,
  output logic        si,
  input  logic        so
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] div_last = CW'(DIV - 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_low  = 2'd1;
  localparam logic [1:0] st_high = 2'd2;
  localparam logic [1:0] st_done = 2'd3;

  logic [1:0]    state;
  logic [31:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic [5:0]    nbits;
  logic [5:0]    wlen_bits;
  logic [5:0]    bit_idx;
  logic [CW-1:0] div_cnt;
  logic          rd_en;
  logic [5:0]    accept_wbits;
  logic [5:0]    accept_nbits;

  // Lengths above four bytes saturate to a full 32-bit write.
  always_comb begin
    accept_wbits = (write_len > 3'd4) ? 6'd32 : {write_len, 3'b000};
    accept_nbits = accept_wbits + (read_len ? 6'd8 : 6'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= st_idle;
      sck       <= 1'b0;
      si        <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      read_data <= 8'h00;
      tx_sr     <= 32'h0;
      rx_sr     <= 8'h00;
      nbits     <= 6'd0;
      wlen_bits <= 6'd0;
      bit_idx   <= 6'd0;
      div_cnt   <= '0;
      rd_en     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        st_idle: begin
          if (send) begin
            tx_sr     <= write_data;
            nbits     <= accept_nbits;
            wlen_bits <= accept_wbits;
            rd_en     <= read_len;
            bit_idx   <= 6'd0;
            div_cnt   <= '0;
            rx_sr     <= 8'h00;
            busy      <= 1'b1;
            if (accept_nbits == 6'd0) begin
              state <= st_done;
              done  <= 1'b1;
            end else begin
              // A read-only burst must keep si low from its very first bit.
              si    <= (accept_wbits != 6'd0) & write_data[31];
              state <= st_low;
            end
          end
        end
        st_low: begin
          if (div_cnt == div_last) begin
            div_cnt <= '0;
            sck     <= 1'b1;
            state   <= st_high;
            if (bit_idx >= wlen_bits)
              rx_sr <= {rx_sr[6:0], so};
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        st_high: begin
          if (div_cnt == div_last) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            if (bit_idx == nbits - 6'd1) begin
              state <= st_done;
              done  <= 1'b1;
              si    <= 1'b0;
              if (rd_en)
                read_data <= rx_sr;
            end else begin
              bit_idx <= bit_idx + 6'd1;
              tx_sr   <= {tx_sr[30:0], 1'b0};
              si      <= ((bit_idx + 6'd1) < wlen_bits) ? tx_sr[30] : 1'b0;
              state   <= st_low;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        st_done: begin
          // send is deliberately not looked at here so a held level cannot retrigger early.
          busy  <= 1'b0;
          sck   <= 1'b0;
          si    <= 1'b0;
          state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_engine.sv
// Scoreboard bench for spi_txn_engine: one instance at DIV=1 and one at DIV=3, with an SPI
// slave model that captures si on sck rising edges and returns a byte on so.
module tb_spi_txn_engine;

  logic        clock = 1'b0;
  logic        rst       [2];
  logic        send      [2];
  logic [31:0] wd        [2];
  logic [2:0]  wl        [2];
  logic        rl        [2];
  logic [7:0]  rd        [2];
  logic        done_o    [2];
  logic        busy      [2];
  logic        sck       [2];
  logic        si        [2];
  logic        so        [2];

  int          rise_cnt  [2];
  logic [63:0] si_cap    [2];
  logic        sck_prev  [2];
  int          base_m    [2];
  int          wbits_m   [2];
  logic [7:0]  slave_m   [2];
  logic [7:0]  prev_rd   [2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] si_exp;
    int          nbits;
    int          lat;
    int          hi;
    logic [7:0]  rd_exp;
  } exp_t;

  typedef struct {
    int          cyc;
    int          hi;
    int          rises;
    logic [63:0] cap;
    logic        busy_acc;
    logic        done_after;
    logic        busy_after;
    logic [7:0]  rd;
  } obs_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  function automatic logic so_model(int rel, int wb, logic [7:0] s);
    if (rel >= wb && rel < wb + 8) return s[7 - (rel - wb)];
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_txn_engine #(.DIV(gi == 0 ? 1 : 3)) dut (
      .clock      (clock),
      .reset      (rst[gi]),
      .send       (send[gi]),
      .write_data (wd[gi]),
      .write_len  (wl[gi]),
      .read_len   (rl[gi]),
      .read_data  (rd[gi]),
      .done       (done_o[gi]),
      .busy       (busy[gi]),
      .sck        (sck[gi]),
      .si         (si[gi]),
      .so         (so[gi])
    );
    assign so[gi] = so_model(rise_cnt[gi] - base_m[gi], wbits_m[gi], slave_m[gi]);
  end

  // Slave model: sck and si are sampled with their pre-edge values, so a rise seen here
  // is captured with the si level that was present while sck was high.
  initial begin
    for (int d = 0; d < 2; d++) begin
      rise_cnt[d] = 0;
      si_cap[d]   = 64'h0;
      sck_prev[d] = 1'b0;
    end
    forever begin
      @(posedge clock);
      for (int d = 0; d < 2; d++) begin
        if (sck[d] === 1'b1 && sck_prev[d] === 1'b0) begin
          si_cap[d]   = {si_cap[d][62:0], si[d]};
          rise_cnt[d] = rise_cnt[d] + 1;
        end
        sck_prev[d] = sck[d];
      end
    end
  end

  task automatic drive_txn(input int d, input logic [31:0] w, input logic [2:0] l,
                           input logic r, input logic [7:0] s, input logic hold,
                           output obs_t o);
    exp_t e;
    int   wb;
    int   dv;
    wb = (l > 3'd4) ? 32 : int'(l) * 8;
    dv = (d == 0) ? 1 : 3;
    e.nbits  = wb + (r ? 8 : 0);
    e.lat    = 1 + 2 * dv * e.nbits;
    e.hi     = dv * e.nbits;
    e.si_exp = (64'(w) >> (32 - wb)) << (r ? 8 : 0);
    e.rd_exp = r ? s : prev_rd[d];
    prev_rd[d] = e.rd_exp;
    sb.push_back(e);

    @(negedge clock);
    wd[d] = w; wl[d] = l; rl[d] = r;
    slave_m[d] = s; wbits_m[d] = wb; base_m[d] = rise_cnt[d];
    send[d] = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) send[d] = 1'b0;
    o.busy_acc = busy[d];
    o.cyc = 1;
    o.hi  = 0;
    while (done_o[d] !== 1'b1 && o.cyc < 5000) begin
      if (sck[d] === 1'b1) o.hi++;
      @(posedge clock);
      #1;
      o.cyc++;
    end
    o.rises = rise_cnt[d] - base_m[d];
    o.cap   = si_cap[d];
    o.rd    = rd[d];
    @(posedge clock);
    #1;
    o.done_after = done_o[d];
    o.busy_after = busy[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; send[d] = 1'b0; wd[d] = 32'h0; wl[d] = 3'd0; rl[d] = 1'b0;
      base_m[d] = 0; wbits_m[d] = 0; slave_m[d] = 8'h00; prev_rd[d] = 8'h00;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) rst[d] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++; if (busy[d] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d] got %b want 0", d, busy[d]); end
      tests++; if (done_o[d] !== 1'b0) begin fails++; $display("FAIL reset_done[%0d] got %b want 0", d, done_o[d]); end
      tests++; if (sck[d] !== 1'b0) begin fails++; $display("FAIL reset_sck[%0d] got %b want 0", d, sck[d]); end
      tests++; if (si[d] !== 1'b0) begin fails++; $display("FAIL reset_si[%0d] got %b want 0", d, si[d]); end
      tests++; if (rd[d] !== 8'h00) begin fails++; $display("FAIL reset_read_data[%0d] got %h want 00", d, rd[d]); end
    end
    $display("[TB] reset checked on both instances");
  endtask

  task automatic test_transfers();
    int          td[6] = '{0, 0, 0, 0, 1, 0};
    logic [31:0] tw[6] = '{32'h0300_1200, 32'h0212_345A, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
                           32'h0512_3456, 32'h8000_0001};
    logic [2:0]  tl[6] = '{3'd3, 3'd4, 3'd6, 3'd0, 3'd1, 3'd2};
    logic        tr[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ts[6] = '{8'hA5, 8'h5A, 8'h81, 8'h77, 8'h3C, 8'h00};
    obs_t o;
    exp_t e;
    logic [63:0] mask;
    for (int i = 0; i < 6; i++) begin
      drive_txn(td[i], tw[i], tl[i], tr[i], ts[i], 1'b0, o);
      e = sb.pop_front();
      mask = (e.nbits == 0) ? 64'h0 : ((64'h1 << e.nbits) - 64'h1);
      tests++; if (o.cyc != e.lat) begin fails++; $display("FAIL txn%0d_latency got %0d want %0d", i, o.cyc, e.lat); end
      tests++; if (o.busy_acc !== 1'b1) begin fails++; $display("FAIL txn%0d_busy_accept got %b want 1", i, o.busy_acc); end
      tests++; if (o.rises != e.nbits) begin fails++; $display("FAIL txn%0d_sck_edges got %0d want %0d", i, o.rises, e.nbits); end
      tests++; if ((o.cap & mask) !== e.si_exp) begin fails++; $display("FAIL txn%0d_si_bits got %h want %h", i, o.cap & mask, e.si_exp); end
      tests++; if (o.hi != e.hi) begin fails++; $display("FAIL txn%0d_sck_high_cycles got %0d want %0d", i, o.hi, e.hi); end
      tests++; if (o.rd !== e.rd_exp) begin fails++; $display("FAIL txn%0d_read_data got %h want %h", i, o.rd, e.rd_exp); end
      tests++; if (o.done_after !== 1'b0) begin fails++; $display("FAIL txn%0d_done_pulse got %b want 0", i, o.done_after); end
      tests++; if (o.busy_after !== 1'b0) begin fails++; $display("FAIL txn%0d_busy_after got %b want 0", i, o.busy_after); end
      $display("[TB] txn%0d dut%0d wd=%h wl=%0d rl=%0d lat=%0d rd=%h", i, td[i], tw[i], tl[i], tr[i], o.cyc, o.rd);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   start;
    int   busy_seen;
    drive_txn(0, 32'h9C00_0000, 3'd1, 1'b0, 8'h00, 1'b1, o);
    e = sb.pop_front();
    tests++; if (o.cyc != e.lat) begin fails++; $display("FAIL b2b_first_latency got %0d want %0d", o.cyc, e.lat); end
    tests++; if (o.busy_after !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap_busy got %b want 0", o.busy_after); end
    tests++; if (o.done_after !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap_done got %b want 0", o.done_after); end
    $display("[TB] b2b first lat=%0d gap_busy=%b", o.cyc, o.busy_after);
    drive_txn(0, 32'h41C3_0000, 3'd1, 1'b1, 8'hE7, 1'b0, o);
    e = sb.pop_front();
    tests++; if (o.cyc != e.lat) begin fails++; $display("FAIL b2b_second_latency got %0d want %0d", o.cyc, e.lat); end
    tests++; if ((o.cap & 64'hFFFF) !== e.si_exp) begin fails++; $display("FAIL b2b_second_si got %h want %h", o.cap & 64'hFFFF, e.si_exp); end
    tests++; if (o.rd !== e.rd_exp) begin fails++; $display("FAIL b2b_second_read_data got %h want %h", o.rd, e.rd_exp); end
    start = rise_cnt[0];
    busy_seen = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (busy[0] !== 1'b0) busy_seen++;
    end
    tests++; if (busy_seen != 0 || rise_cnt[0] != start) begin fails++; $display("FAIL b2b_no_extra_txn got busy_cycles=%0d edges=%0d want 0 0", busy_seen, rise_cnt[0] - start); end
    $display("[TB] b2b second lat=%0d rd=%h", o.cyc, o.rd);
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int   k;
    int   start;
    int   busy_seen;
    @(negedge clock);
    base_m[0] = rise_cnt[0]; wbits_m[0] = 32; slave_m[0] = 8'h00;
    wd[0] = 32'hFFFF_FFFF; wl[0] = 3'd4; rl[0] = 1'b0; send[0] = 1'b1;
    @(posedge clock);
    #1;
    send[0] = 1'b0;
    k = 0;
    while ((rise_cnt[0] - base_m[0] < 10 || sck[0] !== 1'b1) && k < 1000) begin
      @(posedge clock);
      #1;
      k++;
    end
    tests++; if (k >= 1000) begin fails++; $display("FAIL rst_mid_reach_bit10 got timeout want bit 10"); end
    #2;
    rst[0] = 1'b1;
    #1;
    tests++; if (sck[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_sck got %b want 0", sck[0]); end
    tests++; if (si[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_si got %b want 0", si[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy[0]); end
    tests++; if (done_o[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", done_o[0]); end
    prev_rd[0] = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst[0] = 1'b0;
    start = rise_cnt[0];
    busy_seen = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (busy[0] !== 1'b0 || done_o[0] !== 1'b0) busy_seen++;
    end
    tests++; if (busy_seen != 0 || rise_cnt[0] != start) begin fails++; $display("FAIL rst_mid_stays_idle got active=%0d edges=%0d want 0 0", busy_seen, rise_cnt[0] - start); end
    $display("[TB] reset mid-transfer at bit 10 after %0d cycles", k);
    drive_txn(0, 32'hA1B2_C3D4, 3'd2, 1'b1, 8'h69, 1'b0, o);
    e = sb.pop_front();
    tests++; if (o.cyc != e.lat) begin fails++; $display("FAIL rst_recover_latency got %0d want %0d", o.cyc, e.lat); end
    tests++; if ((o.cap & 64'hFF_FFFF) !== e.si_exp) begin fails++; $display("FAIL rst_recover_si got %h want %h", o.cap & 64'hFF_FFFF, e.si_exp); end
    tests++; if (o.rd !== e.rd_exp) begin fails++; $display("FAIL rst_recover_read_data got %h want %h", o.rd, e.rd_exp); end
    $display("[TB] recovery txn lat=%0d rd=%h", o.cyc, o.rd);
  endtask

  initial begin
    test_reset();
    test_transfers();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
